mem_line_initiator: RTL and testbench
=====================================

// Module: mem_line_initiator
// PURPOSE
//  L1-side initiator for the 128-bit L2 memory request/response port. It turns one cache line operation into beat
//  traffic: an optional victim writeback (4 single-beat stores), then an optional refill (1 load request returning
//  4 consecutive beats). Beats are assembled into a 512-bit line for the cache. Sits between the L1 miss handler
//  and the L2 SRAM.
// PARAMETERS
//  TAG_BITS        5   width of mem_req_tag/mem_resp_tag
//  ADDR_BITS       12  beat address width; line address = ADDR_BITS-2 bits
//  TIMEOUT_CYCLES  64  cycles without a matching response beat before a load is reissued (MEM_TIMEOUT_EN only)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high reset
//  req_val        in   1          line operation valid
//  req_rdy        out  1          engine idle; accepts when req_val&req_rdy
//  req_wb         in   1          perform writeback of req_wb_data to req_wb_addr
//  req_refill     in   1          perform refill of req_line_addr
//  req_wb_addr    in   ADDR_BITS-2  victim line address
//  req_line_addr  in   ADDR_BITS-2  refill line address
//  req_wb_data    in   512        victim line; beat i = [128*i+:128]
//  resp_val       out  1          one-cycle pulse: operation complete
//  resp_data      out  512        refilled line (valid with resp_val when req_refill was set)
//  err_timeout    out  1          one-cycle pulse per timeout reissue
//  mem_req_val    out  1          memory request valid
//  mem_req_rdy    in   1          memory ready; handshake = mem_req_val&mem_req_rdy
//  mem_req_rw     out  2          2'b00 load (4 beats), 2'b01 store (1 beat)
//  mem_req_addr   out  ADDR_BITS  beat address {line,beat}
//  mem_req_data   out  128        store data
//  mem_req_tag    out  TAG_BITS   load tag
//  mem_resp_val   in   1          response beat valid
//  mem_resp_nack  in   1          response rejected; load must be reissued
//  mem_resp_data  in   128        response beat
//  mem_resp_tag   in   TAG_BITS   response tag
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, req_rdy=0, resp_val=0, err_timeout=0, mem_req_val=0, mem_req_rw=0,
//    mem_req_addr=0, mem_req_data=0, mem_req_tag=0, resp_data=0, tag counter=0. req_rdy=1 from the first cycle after
//    reset is released. Reset mid-operation aborts it. Partial writebacks are not retried. No resp_val is produced.
//  - States: IDLE -> (wb ? WB : refill ? RD_REQ : DONE). WB -> (refill ? RD_REQ : DONE) after 4th store handshake.
//    RD_REQ -> RD_WAIT on load handshake. RD_WAIT -> DONE after beat 3 captured. DONE -> IDLE (resp_val=1 here).
//  - Acceptance latches addresses, wb data and flags. req_rdy drops the next cycle. A request with neither flag set
//    completes: resp_val 2 cycles after acceptance.
//  - WB: 4 store requests rw=01, addr {req_wb_addr,i}, data beat i, i=0..3 in order. Advance i only on handshake.
//    mem_req_val held with stable addr/data until accepted.
//  - RD_REQ: one load rw=00, addr {req_line_addr,2'b00}, tag = tag counter. The counter increments on every load
//    handshake, modulo 2^TAG_BITS. mem_req_val deasserts the cycle after handshake.
//  - RD_WAIT: a beat counts only if mem_resp_val and mem_resp_tag==issued tag. Beat k lands in resp_data[128*k+:128].
//    k wraps 0..3. Mismatched tags are ignored.
//  - mem_resp_nack with a matching tag in RD_WAIT: discard captured beats, k=0, go to RD_REQ (new tag).
//  - Non-matching beats in any state never change resp_data or state.
//  - mem_resp_val arriving in IDLE/WB is ignored.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined: a counter runs in RD_WAIT and clears on each matching beat. When it reaches
//    TIMEOUT_CYCLES: err_timeout pulses 1 cycle, k=0, state -> RD_REQ (new tag, so stale beats are dropped).
//  - Undefined: no counter, RD_WAIT waits indefinitely, err_timeout tied 0.
// TESTING
//  - Refill line 0x10, memory holds beat i = 128'hA0+i -> load addr 12'h040 tag 0.
//    Then resp_val with resp_data = {A3,A2,A1,A0}; req_rdy high next cycle.
//  - Writeback only, line 0x3FF, data beats D0..D3, mem_req_rdy toggling 1/0 -> stores 0xFFC..0xFFF in order, data unchanged.
//    Each store is accepted exactly once; resp_val after 4th handshake.
//  - wb=1, refill=1 -> 4 stores precede the load. Line returned correctly; exactly one resp_val.
//  - Nack on first beat of tag 2 -> reissue with tag 3. Tag-2 beats after the nack are ignored. Final line = tag-3 beats.
//  - Inject beat with tag 7 while waiting on tag 1 -> ignored; line unchanged.
//  - MEM_TIMEOUT_EN, memory silent 64 cycles -> err_timeout pulse, load reissued with tag+1.
//    Assert reset mid-RD_WAIT -> mem_req_val=0, req_rdy=1 the cycle after reset release.

Source files
------------

// File: rtl/mem_line_initiator_if.sv
// 128-bit L2 request/response bus.
// master = line initiator, slave = memory.
interface mem_line_initiator_if #(
  parameter int TAG_BITS  = 5,
  parameter int ADDR_BITS = 12
);
  logic                 mem_req_val;
  logic                 mem_req_rdy;
  logic [1:0]           mem_req_rw;
  logic [ADDR_BITS-1:0] mem_req_addr;
  logic [127:0]         mem_req_data;
  logic [TAG_BITS-1:0]  mem_req_tag;
  logic                 mem_resp_val;
  logic                 mem_resp_nack;
  logic [127:0]         mem_resp_data;
  logic [TAG_BITS-1:0]  mem_resp_tag;

  modport master (
    output mem_req_val, mem_req_rw, mem_req_addr,
    output mem_req_data, mem_req_tag,
    input  mem_req_rdy, mem_resp_val, mem_resp_nack,
    input  mem_resp_data, mem_resp_tag
  );

  modport slave (
    input  mem_req_val, mem_req_rw, mem_req_addr,
    input  mem_req_data, mem_req_tag,
    output mem_req_rdy, mem_resp_val, mem_resp_nack,
    output mem_resp_data, mem_resp_tag
  );
endinterface

// File: rtl/mem_line_initiator.sv
// L1 line initiator: optional 4-store victim writeback, then 4-beat refill.
// Define MEM_TIMEOUT_EN to reissue loads stalled for TIMEOUT_CYCLES.
module mem_line_initiator #(
  parameter int TAG_BITS       = 5,
  parameter int ADDR_BITS      = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic                 req_wb,
  input  logic                 req_refill,
  input  logic [ADDR_BITS-3:0] req_wb_addr,
  input  logic [ADDR_BITS-3:0] req_line_addr,
  input  logic [511:0]         req_wb_data,
  output logic                 resp_val,
  output logic [511:0]         resp_data,
  output logic                 err_timeout,
  mem_line_initiator_if.master mem
);
  typedef enum logic [2:0] {
    IDLE, WB, RD_REQ, RD_WAIT, DONE
  } state_t;

  state_t               state, state_n;
  logic [1:0]           beat, beat_n, beat_inc;
  logic [TAG_BITS-1:0]  tag_cnt, tag_cnt_n;
  logic [ADDR_BITS-3:0] wb_line_q, rd_line_q;
  logic [511:0]         wb_data_q;
  logic                 refill_q;
  logic                 accept, req_hs, match;
  logic                 req_val_n, resp_val_n;
  logic [1:0]           rw_n;
  logic [ADDR_BITS-1:0] addr_n;
  logic [127:0]         data_n;
  logic [TAG_BITS-1:0]  tag_n;
  logic [511:0]         resp_data_n;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer, timer_n;
  logic          err_n;
`endif

  assign accept   = req_val & req_rdy;
  assign req_hs   = mem.mem_req_val & mem.mem_req_rdy;
  assign match    = mem.mem_resp_val &
                    (mem.mem_resp_tag == mem.mem_req_tag);
  assign beat_inc = beat + 2'd1;

  // next state and next values of all registered outputs
  always_comb begin
    state_n     = state;
    beat_n      = beat;
    tag_cnt_n   = tag_cnt;
    req_val_n   = mem.mem_req_val;
    rw_n        = mem.mem_req_rw;
    addr_n      = mem.mem_req_addr;
    data_n      = mem.mem_req_data;
    tag_n       = mem.mem_req_tag;
    resp_data_n = resp_data;
    resp_val_n  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timer_n     = '0;
    err_n       = 1'b0;
`endif
    unique case (state)
      IDLE: if (accept) begin
        beat_n = 2'd0;
        if (req_wb) begin
          state_n   = WB;
          req_val_n = 1'b1;
          rw_n      = 2'b01;
          addr_n    = {req_wb_addr, 2'b00};
          data_n    = req_wb_data[127:0];
        end else if (req_refill) begin
          state_n   = RD_REQ;
          req_val_n = 1'b1;
          rw_n      = 2'b00;
          addr_n    = {req_line_addr, 2'b00};
          tag_n     = tag_cnt;
        end else begin
          state_n   = DONE;
        end
      end
      WB: if (req_hs) begin
        if (beat == 2'd3) begin
          beat_n = 2'd0;
          if (refill_q) begin
            state_n = RD_REQ;
            rw_n    = 2'b00;
            addr_n  = {rd_line_q, 2'b00};
            tag_n   = tag_cnt;
          end else begin
            state_n   = DONE;
            req_val_n = 1'b0;
          end
        end else begin
          beat_n = beat_inc;
          addr_n = {wb_line_q, beat_inc};
          data_n = wb_data_q[{beat_inc, 7'd0} +: 128];
        end
      end
      RD_REQ: if (req_hs) begin
        state_n   = RD_WAIT;
        req_val_n = 1'b0;
        tag_cnt_n = tag_cnt + 1'b1;
        beat_n    = 2'd0;
      end
      RD_WAIT: if (match) begin
        if (mem.mem_resp_nack) begin
          state_n   = RD_REQ;
          beat_n    = 2'd0;
          req_val_n = 1'b1;
          rw_n      = 2'b00;
          addr_n    = {rd_line_q, 2'b00};
          tag_n     = tag_cnt;
        end else begin
          resp_data_n[{beat, 7'd0} +: 128] = mem.mem_resp_data;
          beat_n = beat_inc;
          if (beat == 2'd3) state_n = DONE;
        end
      end
      DONE: begin
        resp_val_n = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    if (state == RD_WAIT && !match) begin
      timer_n = timer + 1'b1;
      if (timer_n == TW'(TIMEOUT_CYCLES)) begin
        timer_n   = '0;
        err_n     = 1'b1;
        state_n   = RD_REQ;
        beat_n    = 2'd0;
        req_val_n = 1'b1;
        rw_n      = 2'b00;
        addr_n    = {rd_line_q, 2'b00};
        tag_n     = tag_cnt;
      end
    end
`endif
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      beat             <= 2'd0;
      tag_cnt          <= '0;
      req_rdy          <= 1'b0;
      resp_val         <= 1'b0;
      resp_data        <= '0;
      mem.mem_req_val  <= 1'b0;
      mem.mem_req_rw   <= 2'b00;
      mem.mem_req_addr <= '0;
      mem.mem_req_data <= '0;
      mem.mem_req_tag  <= '0;
    end else begin
      state            <= state_n;
      beat             <= beat_n;
      tag_cnt          <= tag_cnt_n;
      req_rdy          <= (state_n == IDLE);
      resp_val         <= resp_val_n;
      resp_data        <= resp_data_n;
      mem.mem_req_val  <= req_val_n;
      mem.mem_req_rw   <= rw_n;
      mem.mem_req_addr <= addr_n;
      mem.mem_req_data <= data_n;
      mem.mem_req_tag  <= tag_n;
    end
  end

  // operation latched on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      wb_line_q <= req_wb_addr;
      rd_line_q <= req_line_addr;
      wb_data_q <= req_wb_data;
      refill_q  <= req_refill;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // response watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      timer       <= timer_n;
      err_timeout <= err_n;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_mem_line_initiator.sv
// Randomized bench for mem_line_initiator with a behavioural L2 memory
// and a transaction-level model of the expected request stream.
module tb_mem_line_initiator;
  typedef struct packed {
    logic [1:0]   rw;
    logic [11:0]  addr;
    logic [127:0] data;
    logic [4:0]   tag;
  } req_rec_t;

  typedef struct packed {
    logic [4:0]   tag;
    logic         nack;
    logic [127:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_val = 1'b0;
  logic         req_rdy;
  logic         req_wb = 1'b0;
  logic         req_refill = 1'b0;
  logic [9:0]   req_wb_addr = '0;
  logic [9:0]   req_line_addr = '0;
  logic [511:0] req_wb_data = '0;
  logic         resp_val;
  logic [511:0] resp_data;
  logic         err_timeout;

  always #5 clk = ~clk;

  mem_line_initiator_if #(.TAG_BITS(5), .ADDR_BITS(12)) bus ();

  mem_line_initiator #(
    .TAG_BITS(5), .ADDR_BITS(12), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_wb(req_wb), .req_refill(req_refill),
    .req_wb_addr(req_wb_addr), .req_line_addr(req_line_addr),
    .req_wb_data(req_wb_data),
    .resp_val(resp_val), .resp_data(resp_data),
    .err_timeout(err_timeout),
    .mem(bus)
  );

  logic [127:0] mem     [0:4095];
  logic [127:0] ref_mem [0:4095];
  req_rec_t     reqs[$];
  req_rec_t     exp[$];
  beat_t        rq[$];
  int           ld_cycs[$];
  int checks = 0, errors = 0;
  int model_tag = 0;
  int rdy_mode = 0;
  int resp_cnt = 0, err_cnt = 0, err_cyc = 0, viol = 0, cyc = 0;
  bit silent_first = 0, nack_first = 0, stray_en = 0;
  logic [511:0] last_line = '0;

  // memory slave and bus monitor, acting 1ns after each rising edge
  bit       hold = 0, after_ld = 0;
  req_rec_t h;
  always @(posedge clk) begin
    req_rec_t r;
    beat_t    b;
    #1;
    cyc++;
    if (reset) begin
      rq.delete();
      bus.mem_req_rdy   = 1'b1;
      bus.mem_resp_val  = 1'b0;
      bus.mem_resp_nack = 1'b0;
      bus.mem_resp_data = '0;
      bus.mem_resp_tag  = '0;
      hold = 0; after_ld = 0;
      silent_first = 0; nack_first = 0;
    end else begin
      if (resp_val) resp_cnt++;
      if (err_timeout) begin err_cnt++; err_cyc = cyc; end
      if (after_ld && bus.mem_req_val) viol++;
      if (hold && !(bus.mem_req_val && bus.mem_req_rw == h.rw &&
          bus.mem_req_addr == h.addr &&
          (h.rw == 2'b01 ? bus.mem_req_data == h.data
                         : bus.mem_req_tag == h.tag)))
        viol++;
      hold = 0; after_ld = 0;
      case (rdy_mode)
        0: bus.mem_req_rdy = 1'b1;
        1: bus.mem_req_rdy = ~bus.mem_req_rdy;
        default: bus.mem_req_rdy = 1'($urandom_range(0, 1));
      endcase
      if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
        b = rq.pop_front();
        bus.mem_resp_val  = 1'b1;
        bus.mem_resp_nack = b.nack;
        bus.mem_resp_tag  = b.tag;
        bus.mem_resp_data = b.data;
      end else begin
        bus.mem_resp_val  = 1'b0;
        bus.mem_resp_nack = 1'($urandom_range(0, 1));
        bus.mem_resp_tag  = 5'($urandom);
        bus.mem_resp_data = {4{$urandom}};
      end
      r.rw   = bus.mem_req_rw;
      r.addr = bus.mem_req_addr;
      r.data = bus.mem_req_data;
      r.tag  = bus.mem_req_tag;
      if (bus.mem_req_val && bus.mem_req_rdy) begin
        reqs.push_back(r);
        if (r.rw == 2'b01) begin
          mem[r.addr] = r.data;
        end else begin
          after_ld = 1;
          ld_cycs.push_back(cyc);
          if (silent_first) begin
            silent_first = 0;
          end else if (nack_first) begin
            nack_first = 0;
            rq.push_back({r.tag, 1'b1, 128'h0});
            for (int k = 1; k < 4; k++)
              rq.push_back({r.tag, 1'b0, ~mem[r.addr + 12'(k)]});
          end else begin
            for (int k = 0; k < 4; k++) begin
              if (stray_en && k == 1)
                rq.push_back({r.tag + 5'd6, 1'b0, {4{$urandom}}});
              rq.push_back({r.tag, 1'b0, mem[r.addr + 12'(k)]});
            end
          end
        end
      end else if (bus.mem_req_val) begin
        hold = 1;
        h = r;
      end
    end
  end

  // reference model: expected request stream and returned line
  function automatic logic [511:0] model_op(
    input bit wb, input bit refill, input logic [9:0] wl,
    input logic [9:0] rl, input logic [511:0] d, input int nloads);
    req_rec_t     r;
    logic [511:0] line;
    line = '0;
    exp.delete();
    if (wb) begin
      for (int i = 0; i < 4; i++) begin
        r.rw = 2'b01; r.addr = {wl, 2'(i)};
        r.data = d[128*i +: 128]; r.tag = '0;
        exp.push_back(r);
        ref_mem[r.addr] = r.data;
      end
    end
    if (refill) begin
      for (int n = 0; n < nloads; n++) begin
        r.rw = 2'b00; r.addr = {rl, 2'b00};
        r.data = '0; r.tag = 5'(model_tag);
        model_tag++;
        exp.push_back(r);
      end
      for (int i = 0; i < 4; i++)
        line[128*i +: 128] = ref_mem[{rl, 2'(i)}];
    end
    return line;
  endfunction

  // index of first difference between observed and expected streams
  function automatic int first_diff();
    int n;
    n = (reqs.size() < exp.size()) ? reqs.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      if (reqs[i].rw !== exp[i].rw || reqs[i].addr !== exp[i].addr)
        return i;
      if (exp[i].rw == 2'b01 && reqs[i].data !== exp[i].data) return i;
      if (exp[i].rw == 2'b00 && reqs[i].tag !== exp[i].tag) return i;
    end
    if (reqs.size() != exp.size()) return n;
    return -1;
  endfunction

  task automatic run_op(input bit wb, input bit refill,
                        input logic [9:0] wl, input logic [9:0] rl,
                        input logic [511:0] d, output int lat);
    int n;
    n = 0;
    while (!req_rdy && n < 100) begin @(negedge clk); n++; end
    reqs.delete(); ld_cycs.delete();
    resp_cnt = 0; err_cnt = 0; viol = 0;
    req_val = 1'b1; req_wb = wb; req_refill = refill;
    req_wb_addr = wl; req_line_addr = rl; req_wb_data = d;
    @(negedge clk);
    req_val = 1'b0;
    lat = 1;
    while (resp_cnt == 0 && lat < 3000) begin @(negedge clk); lat++; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({req_rdy, resp_val, err_timeout, bus.mem_req_val} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000",
               {req_rdy, resp_val, err_timeout, bus.mem_req_val});
    end
    checks++;
    if ({bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_tag} !== '0 ||
        bus.mem_req_data !== '0 || resp_data !== '0) begin
      errors++;
      $display("FAIL reset_bus got rw=%0d addr=%h tag=%0d data=%h want 0",
               bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_tag,
               bus.mem_req_data);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy got %b want 1", req_rdy);
    end
  endtask

  task automatic test_refill();
    logic [511:0] line;
    int lat, d;
    for (int i = 0; i < 4; i++) begin
      mem[12'h040 + 12'(i)]     = 128'hA0 + 128'(i);
      ref_mem[12'h040 + 12'(i)] = 128'hA0 + 128'(i);
    end
    rdy_mode = 0;
    line = model_op(0, 1, '0, 10'h010, '0, 1);
    last_line = line;
    run_op(0, 1, '0, 10'h010, '0, lat);
    checks++;
    if (resp_cnt !== 1) begin
      errors++;
      $display("FAIL refill_resp got %0d pulses want 1", resp_cnt);
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL refill_req idx %0d got %0d reqs want %0d",
               d, reqs.size(), exp.size());
    end
    checks++;
    if (resp_data !== line) begin
      errors++;
      $display("FAIL refill_line got %h want %h", resp_data, line);
    end
    checks++;
    if (req_rdy !== 1'b1 || viol !== 0) begin
      errors++;
      $display("FAIL refill_rdy got rdy=%b viol=%0d want 1/0", req_rdy, viol);
    end
  endtask

  task automatic test_writeback();
    logic [511:0] d;
    logic [511:0] line;
    int lat, df;
    d = {16{$urandom}};
    rdy_mode = 1;
    line = model_op(1, 0, 10'h3FF, '0, d, 0);
    run_op(1, 0, 10'h3FF, '0, d, lat);
    checks++;
    if (resp_cnt !== 1) begin
      errors++;
      $display("FAIL wb_resp got %0d pulses want 1", resp_cnt);
    end
    df = first_diff();
    checks++;
    if (df >= 0) begin
      errors++;
      $display("FAIL wb_req idx %0d got %0d reqs want %0d",
               df, reqs.size(), exp.size());
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL wb_hold got %0d unstable cycles want 0", viol);
    end
    rdy_mode = 0;
  endtask

  task automatic test_stray();
    logic [511:0] line;
    logic [9:0]   rl;
    int lat, df;
    for (int i = 0; i < 2; i++)
      rq.push_back({5'($urandom), 1'(i), {4{$urandom}}});
    repeat (6) @(negedge clk);
    checks++;
    if (resp_data !== last_line || req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL idle_stray got rdy=%b line=%h want 1 line=%h",
               req_rdy, resp_data, last_line);
    end
    rl = 10'($urandom);
    stray_en = 1;
    line = model_op(0, 1, '0, rl, '0, 1);
    last_line = line;
    run_op(0, 1, '0, rl, '0, lat);
    stray_en = 0;
    df = first_diff();
    checks++;
    if (df >= 0 || resp_cnt !== 1) begin
      errors++;
      $display("FAIL stray_req idx %0d resp %0d want -1/1", df, resp_cnt);
    end
    checks++;
    if (resp_data !== line) begin
      errors++;
      $display("FAIL stray_line got %h want %h", resp_data, line);
    end
  endtask

  task automatic test_nack();
    logic [511:0] line;
    logic [9:0]   rl;
    int lat, df;
    rl = 10'($urandom);
    nack_first = 1;
    line = model_op(0, 1, '0, rl, '0, 2);
    last_line = line;
    run_op(0, 1, '0, rl, '0, lat);
    df = first_diff();
    checks++;
    if (df >= 0 || resp_cnt !== 1) begin
      errors++;
      $display("FAIL nack_req idx %0d got %0d reqs resp %0d want -1/1",
               df, reqs.size(), resp_cnt);
    end
    checks++;
    if (resp_data !== line) begin
      errors++;
      $display("FAIL nack_line got %h want %h", resp_data, line);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] line, d;
    logic [9:0]   wl, rl;
    bit           wb, rf;
    int lat, df;
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) begin
      wb = 1'($urandom_range(0, 1));
      rf = 1'($urandom_range(0, 1));
      wl = 10'($urandom);
      rl = 10'($urandom);
      d  = {16{$urandom}};
      if (i == 0) begin wb = 1; rf = 1; rl = wl; end
      if (i == 1) begin wb = 0; rf = 0; end
      line = model_op(wb, rf, wl, rl, d, 1);
      if (rf) last_line = line;
      run_op(wb, rf, wl, rl, d, lat);
      df = first_diff();
      checks++;
      if (df >= 0 || resp_cnt !== 1 || viol !== 0) begin
        errors++;
        $display("FAIL b2b_req op %0d idx %0d resp %0d viol %0d", i, df,
                 resp_cnt, viol);
      end
      if (rf) begin
        checks++;
        if (resp_data !== line) begin
          errors++;
          $display("FAIL b2b_line op %0d got %h want %h", i, resp_data, line);
        end
      end
      if (!wb && !rf) begin
        checks++;
        if (lat !== 2) begin
          errors++;
          $display("FAIL b2b_lat got %0d want 2", lat);
        end
      end
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    logic [511:0] line;
    logic [9:0]   rl;
    int n, lat, df;
    n = 0;
    while (!req_rdy && n < 100) begin @(negedge clk); n++; end
    reqs.delete();
    silent_first = 1;
    req_val = 1'b1; req_wb = 1'b0; req_refill = 1'b1;
    req_line_addr = 10'($urandom);
    @(negedge clk);
    req_val = 1'b0;
    n = 0;
    while (reqs.size() == 0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (reqs.size() !== 1) begin
      errors++;
      $display("FAIL mid_load got %0d loads want 1", reqs.size());
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_tag = 0;
    @(negedge clk);
    checks++;
    if (bus.mem_req_val !== 1'b0 || req_rdy !== 1'b1 || resp_data !== '0) begin
      errors++;
      $display("FAIL mid_reset got val=%b rdy=%b want 0/1",
               bus.mem_req_val, req_rdy);
    end
    rl = 10'($urandom);
    line = model_op(0, 1, '0, rl, '0, 1);
    last_line = line;
    run_op(0, 1, '0, rl, '0, lat);
    df = first_diff();
    checks++;
    if (df >= 0 || resp_data !== line) begin
      errors++;
      $display("FAIL mid_after idx %0d line %h want %h", df, resp_data, line);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    logic [511:0] line;
    logic [9:0]   rl;
    int lat, df, gap;
    rl = 10'($urandom);
    silent_first = 1;
    line = model_op(0, 1, '0, rl, '0, 2);
    last_line = line;
    run_op(0, 1, '0, rl, '0, lat);
    gap = (ld_cycs.size() > 0) ? err_cyc - ld_cycs[0] : -1;
    checks++;
    if (err_cnt !== 1 || gap < 64 || gap > 66) begin
      errors++;
      $display("FAIL timeout_err got %0d pulses gap %0d want 1 gap 65",
               err_cnt, gap);
    end
    df = first_diff();
    checks++;
    if (df >= 0 || resp_data !== line) begin
      errors++;
      $display("FAIL timeout_req idx %0d line %h want %h",
               df, resp_data, line);
    end
  endtask
`endif

  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem[a] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[a] = mem[a];
    end
    test_reset();
    test_refill();
    test_writeback();
    test_stray();
    test_nack();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
